fwd_hazard_unit: RTL and testbench

Parametrised forwarding and hazard unit for the ARM pipeline, replacing the fixed two-source, MEM/WB-only forwarding selector. It keeps its own shift register of in-flight destination writes for the stages downstream of EXE and produces per-operand bypass selects for the instruction in EXE. It also generates the load-use / no-forwarding stall. It sits beside the EXE stage and drives the operand muxes and the ID/EXE hold logic.

---
 rtl/fwd_hazard_unit_pkg.sv | 43 ++++
 rtl/fwd_hazard_unit_src_match.sv | 75 +++++++
 rtl/fwd_hazard_unit.sv | 159 +++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_unit_pkg
// Purpose  : Shared constants for the forwarding / hazard unit: operand-mux
//            select encodings, register address width and the layout of one
//            tracking entry.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fwd_hazard_unit_pkg;

  // Operand mux select encodings (0 = register file, k = tracked stage k-1)
  localparam logic [1:0] FORWARDING_NON_SELECT = 2'd0;
  localparam logic [1:0] FORWARDING_MEM_SELECT = 2'd1;
  localparam logic [1:0] FORWARDING_WB_SELECT  = 2'd2;

  // Register-file address width of the ARM pipeline
  localparam int REG_ADDR_W = 4;

  // Width of the per-entry "cycles until forwardable" counter
  localparam int RDY_CNT_W = 4;

  // Reference layout of one tracking entry (MSB first). The RTL stores
  // entries flattened with the same field order so ADDR_W can be overridden.
  typedef struct packed {
    logic                  valid;
    logic                  wb_en;
    logic [RDY_CNT_W-1:0]  rdy_cnt;
    logic [REG_ADDR_W-1:0] dest;
  } track_entry_t;

  // Flattened entry width for a given register address width
  function automatic int entry_w(input int addr_w);
    return addr_w + RDY_CNT_W + 2;
  endfunction

  // Saturating decrement of the ready counter
  function automatic logic [RDY_CNT_W-1:0] rdy_dec(input logic [RDY_CNT_W-1:0] cnt);
    return (cnt == '0) ? cnt : cnt - 1'b1;
  endfunction

endpackage : fwd_hazard_unit_pkg
`default_nettype wire

// File: rtl/fwd_hazard_unit_src_match.sv
`default_nettype none
// ============================================================================
// Module   : fwd_src_match
// Purpose  : Per-operand producer search over the tracked in-flight writes.
//            Picks the youngest matching producer and either selects its
//            bypass path or requests a stall when its data is not ready yet
//            (or forwarding is disabled).
// Ports    : fwd_en_i     - forwarding enable
//            src_i        - operand source register
//            src_valid_i  - operand is actually read
//            entries_i    - flattened tracking entries, stage 0 in the LSBs
//            sel_o        - operand mux select
//            stall_req_o  - this operand needs the instruction held
// Revision : 1.0 - initial release
// ============================================================================
module fwd_src_match
  import fwd_hazard_unit_pkg::*;
#(
  parameter int ADDR_W     = REG_ADDR_W,
  parameter int NUM_STAGES = 2,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                                    fwd_en_i,
  input  logic [ADDR_W-1:0]                       src_i,
  input  logic                                    src_valid_i,
  input  logic [NUM_STAGES*entry_w(ADDR_W)-1:0]   entries_i,
  output logic [SEL_W-1:0]                        sel_o,
  output logic                                    stall_req_o
);

  localparam int EW      = entry_w(ADDR_W);
  localparam int RDY_LSB = ADDR_W;
  localparam int WB_BIT  = ADDR_W + RDY_CNT_W;
  localparam int VLD_BIT = ADDR_W + RDY_CNT_W + 1;

  logic                 w_found;
  logic [SEL_W-1:0]     w_hit_sel;
  logic [RDY_CNT_W-1:0] w_hit_rdy;

  // Scan oldest to youngest so the last hit kept is the youngest producer.
  always_comb begin
    w_found   = 1'b0;
    w_hit_sel = '0;
    w_hit_rdy = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (src_valid_i &&
          entries_i[k*EW + VLD_BIT] &&
          entries_i[k*EW + WB_BIT] &&
          (entries_i[k*EW +: ADDR_W] == src_i)) begin
        w_found   = 1'b1;
        w_hit_sel = SEL_W'(k + 1);
        w_hit_rdy = entries_i[k*EW + RDY_LSB +: RDY_CNT_W];
      end
    end
  end

  always_comb begin
    sel_o       = SEL_W'(FORWARDING_NON_SELECT);
    stall_req_o = 1'b0;
    if (fwd_en_i) begin
      if (w_found) begin
        if (w_hit_rdy == '0) begin
          sel_o = w_hit_sel;
        end else begin
          stall_req_o = 1'b1;
        end
      end
    end else begin
      // No bypass paths: any in-flight producer interlocks.
      stall_req_o = w_found;
    end
  end

endmodule : fwd_src_match
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_unit
// Purpose  : Forwarding and hazard unit beside the EXE stage. Tracks the
//            destination writes of the instructions downstream of EXE in a
//            shift register and produces per-operand bypass selects plus the
//            load-use / no-forwarding stall for the instruction in EXE.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            fwd_en_i         - forwarding enable
//            stall_in_i       - global freeze, tracking state holds
//            flush_i          - kill EXE instruction (enters as bubble)
//            exe_valid_i      - EXE holds a real instruction
//            exe_dest_i       - EXE destination register
//            exe_wb_en_i      - EXE instruction writes back
//            exe_mem_read_i   - EXE instruction is a load
//            src_i            - EXE sources, operand i at [i*ADDR_W +: ADDR_W]
//            src_valid_i      - operand i is read
//            src_sel_o        - per-operand select, operand i at [i*SEL_W +: SEL_W]
//            hazard_stall_o   - hold EXE/ID, bubble downstream
//            stall_cycles_o   - (FWD_HAZARD_PERF_EN) stall cycle counter
//            fwd_events_o     - (FWD_HAZARD_PERF_EN) forwarded operand counter
// Config   : define FWD_HAZARD_PERF_EN to add the performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int ADDR_W     = REG_ADDR_W,
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 2,
  parameter int LOAD_LAT   = 1,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fwd_en_i,
  input  logic                      stall_in_i,
  input  logic                      flush_i,
  input  logic                      exe_valid_i,
  input  logic [ADDR_W-1:0]         exe_dest_i,
  input  logic                      exe_wb_en_i,
  input  logic                      exe_mem_read_i,
  input  logic [NUM_SRC*ADDR_W-1:0] src_i,
  input  logic [NUM_SRC-1:0]        src_valid_i,
  output logic [NUM_SRC*SEL_W-1:0]  src_sel_o,
  output logic                      hazard_stall_o
`ifdef FWD_HAZARD_PERF_EN
  ,
  output logic [31:0]               stall_cycles_o,
  output logic [31:0]               fwd_events_o
`endif
);

  localparam int EW      = entry_w(ADDR_W);
  localparam int RDY_LSB = ADDR_W;

  logic [NUM_STAGES*EW-1:0] r_track_q;
  logic [NUM_STAGES*EW-1:0] w_track_d;
  logic [NUM_SRC*SEL_W-1:0] w_sel;
  logic [NUM_SRC-1:0]       w_req;
  logic                     w_hazard;
  logic                     w_new_valid;
  logic [EW-1:0]            w_new_entry;

  // --------------------------------------------------------------------------
  // Per-operand producer search
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_src_match #(
        .ADDR_W     (ADDR_W),
        .NUM_STAGES (NUM_STAGES),
        .SEL_W      (SEL_W)
      ) u_match (
        .fwd_en_i    (fwd_en_i),
        .src_i       (src_i[i*ADDR_W +: ADDR_W]),
        .src_valid_i (src_valid_i[i]),
        .entries_i   (r_track_q),
        .sel_o       (w_sel[i*SEL_W +: SEL_W]),
        .stall_req_o (w_req[i])
      );
    end
  endgenerate

  // A killed or empty EXE slot never holds the pipe.
  assign w_hazard = (|w_req) & exe_valid_i & ~flush_i;

  // A stalled instruction stays in EXE, so a bubble is what moves on.
  assign w_new_valid = exe_valid_i & ~flush_i & ~w_hazard;
  assign w_new_entry = {w_new_valid,
                        exe_wb_en_i,
                        (exe_mem_read_i ? RDY_CNT_W'(LOAD_LAT) : RDY_CNT_W'(0)),
                        exe_dest_i};

  // --------------------------------------------------------------------------
  // Tracking shift register next state
  // --------------------------------------------------------------------------
  always_comb begin
    logic [EW-1:0] w_mv;
    w_track_d = r_track_q;
    w_mv      = '0;
    if (!stall_in_i) begin
      w_track_d[0 +: EW] = w_new_entry;
      for (int k = 1; k < NUM_STAGES; k++) begin
        w_mv = r_track_q[(k-1)*EW +: EW];
        w_mv[RDY_LSB +: RDY_CNT_W] = rdy_dec(w_mv[RDY_LSB +: RDY_CNT_W]);
        w_track_d[k*EW +: EW] = w_mv;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_track_q <= '0;
    end else begin
      r_track_q <= w_track_d;
    end
  end

  // Outputs are forced low while reset is held.
  assign src_sel_o      = rst ? '0 : w_sel;
  assign hazard_stall_o = w_hazard & ~rst;

`ifdef FWD_HAZARD_PERF_EN
  // --------------------------------------------------------------------------
  // Performance counters (wrap at 2^32)
  // --------------------------------------------------------------------------
  logic [31:0] r_stall_cycles_q;
  logic [31:0] r_fwd_events_q;
  logic [31:0] w_fwd_cnt;

  always_comb begin
    w_fwd_cnt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_sel[i*SEL_W +: SEL_W] != '0) begin
        w_fwd_cnt = w_fwd_cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles_q <= '0;
      r_fwd_events_q   <= '0;
    end else if (!stall_in_i) begin
      if (w_hazard) begin
        r_stall_cycles_q <= r_stall_cycles_q + 32'd1;
      end else begin
        r_fwd_events_q <= r_fwd_events_q + w_fwd_cnt;
      end
    end
  end

  assign stall_cycles_o = r_stall_cycles_q;
  assign fwd_events_o   = r_fwd_events_q;
`endif

endmodule : fwd_hazard_unit
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_hazard_unit
// Purpose  : Directed self-checking bench for fwd_hazard_unit with default
//            parameters (ADDR_W=4, NUM_SRC=2, NUM_STAGES=2, LOAD_LAT=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       fwd_en;
  logic       stall_in;
  logic       flush;
  logic       exe_valid;
  logic [3:0] exe_dest;
  logic       exe_wb_en;
  logic       exe_mem_read;
  logic [7:0] src;
  logic [1:0] src_valid;
  logic [3:0] src_sel;
  logic       hazard_stall;
`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] fwd_events;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit u_dut (
    .clk            (clk),
    .rst            (rst),
    .fwd_en_i       (fwd_en),
    .stall_in_i     (stall_in),
    .flush_i        (flush),
    .exe_valid_i    (exe_valid),
    .exe_dest_i     (exe_dest),
    .exe_wb_en_i    (exe_wb_en),
    .exe_mem_read_i (exe_mem_read),
    .src_i          (src),
    .src_valid_i    (src_valid),
    .src_sel_o      (src_sel),
    .hazard_stall_o (hazard_stall)
`ifdef FWD_HAZARD_PERF_EN
    ,
    .stall_cycles_o (stall_cycles),
    .fwd_events_o   (fwd_events)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [1:0] s0,
                            input logic [1:0] s1, input logic st);
    chk({tag, ".sel0"}, 32'(src_sel[1:0]), 32'(s0));
    chk({tag, ".sel1"}, 32'(src_sel[3:2]), 32'(s1));
    chk({tag, ".stall"}, 32'(hazard_stall), 32'(st));
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic wb,
                       input logic ld, input logic [3:0] s0, input logic [3:0] s1,
                       input logic [1:0] sv);
    exe_valid    = v;
    exe_dest     = d;
    exe_wb_en    = wb;
    exe_mem_read = ld;
    src          = {s1, s0};
    src_valid    = sv;
  endtask

  // Advance to just after the next rising edge.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; fwd_en = 1'b1; stall_in = 1'b0; flush = 1'b0;
    drive(1, 4'd1, 1, 0, 4'd3, 4'd4, 2'b11);
    repeat (2) @(posedge clk);
    #4;
    expect_out("in_reset", 0, 0, 0);
    next(); rst = 1'b0; #3;
    expect_out("empty", 0, 0, 0);

    // Back-to-back ALU forwarding distances
    next(); drive(1, 4'd3, 1, 0, 4'd6, 4'd7, 2'b11); #3; expect_out("A", 0, 0, 0);
    next(); drive(1, 4'd8, 1, 0, 4'd3, 4'd6, 2'b11); #3; expect_out("fwd_mem", 1, 0, 0);
    next(); drive(1, 4'd9, 1, 0, 4'd3, 4'd1, 2'b11); #3; expect_out("fwd_wb", 2, 0, 0);
    next(); drive(1, 4'd5, 0, 0, 4'd3, 4'd8, 2'b11); #3; expect_out("aged_out", 0, 2, 0);
    next(); drive(1, 4'd6, 1, 0, 4'd5, 4'd9, 2'b11); #3; expect_out("no_wb", 0, 2, 0);

    // Load-use
    next(); drive(1, 4'd5, 1, 1, 4'd0, 4'd0, 2'b00); #3; expect_out("ldr", 0, 0, 0);
    next(); drive(1, 4'd10, 1, 0, 4'd5, 4'd5, 2'b11); #3; expect_out("ld_use", 0, 0, 1);
    next(); #3; expect_out("ld_fwd", 2, 2, 0);
    next(); drive(1, 4'd11, 1, 0, 4'd10, 4'd5, 2'b11); #3; expect_out("bubble", 1, 0, 0);
    next(); drive(1, 4'd7, 1, 0, 4'd10, 4'd11, 2'b10); #3; expect_out("src_valid", 0, 1, 0);

    // Two in-flight writers of r7, then a global freeze
    next(); drive(1, 4'd7, 1, 0, 4'd0, 4'd0, 2'b00); #3; expect_out("K", 0, 0, 0);
    next(); drive(1, 4'd12, 1, 0, 4'd7, 4'd7, 2'b11); #3; expect_out("younger", 1, 1, 0);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next(); #3; expect_out("freeze", 1, 1, 0);
    end
    stall_in = 1'b0; #1; expect_out("thaw", 1, 1, 0);
    next(); drive(1, 4'd13, 1, 0, 4'd7, 4'd7, 2'b11); #3; expect_out("after_freeze", 2, 2, 0);

    // Flush coinciding with a load-use request
    next(); drive(1, 4'd14, 1, 1, 4'd0, 4'd0, 2'b00); #3; expect_out("ldr2", 0, 0, 0);
    next(); drive(1, 4'd15, 1, 0, 4'd14, 4'd13, 2'b11); flush = 1'b1; #3;
    expect_out("flush", 0, 2, 0);
    next(); flush = 1'b0; drive(1, 4'd15, 1, 0, 4'd14, 4'd0, 2'b01); #3;
    expect_out("post_flush", 2, 0, 0);

    // Empty EXE slot never stalls
    next(); drive(1, 4'd3, 1, 1, 4'd0, 4'd0, 2'b00); #3; expect_out("ldr3", 0, 0, 0);
    next(); drive(0, 4'd4, 1, 0, 4'd3, 4'd15, 2'b11); #3; expect_out("exe_invalid", 0, 2, 0);

    // Forwarding disabled: interlock for NUM_STAGES cycles
    next(); fwd_en = 1'b0; drive(1, 4'd2, 1, 0, 4'd0, 4'd0, 2'b00); #3;
    expect_out("nofwd_prod", 0, 0, 0);
    next(); drive(1, 4'd4, 1, 0, 4'd2, 4'd2, 2'b11); #3; expect_out("nofwd_s1", 0, 0, 1);
    next(); #3; expect_out("nofwd_s2", 0, 0, 1);
    next(); #3; expect_out("nofwd_go", 0, 0, 0);
    fwd_en = 1'b1;

    // Reset in the middle of a load-use stall
    next(); drive(1, 4'd9, 1, 1, 4'd0, 4'd0, 2'b00); #3; expect_out("ldr4", 0, 0, 0);
    next(); drive(1, 4'd10, 1, 0, 4'd9, 4'd9, 2'b11); #3; expect_out("ld_use2", 0, 0, 1);
    rst = 1'b1; #1; expect_out("rst_gate", 0, 0, 0);
    next(); rst = 1'b0; #3; expect_out("rst_clear", 0, 0, 0);

`ifdef FWD_HAZARD_PERF_EN
    next(); rst = 1'b1;
    next(); rst = 1'b0;
    drive(1, 4'd5, 1, 1, 4'd0, 4'd0, 2'b00);
    next(); drive(1, 4'd10, 1, 0, 4'd5, 4'd5, 2'b11);
    next();
    next(); drive(1, 4'd0, 0, 0, 4'd0, 4'd0, 2'b00); #3;
    chk("perf.stall_cycles", stall_cycles, 32'd1);
    chk("perf.fwd_events", fwd_events, 32'd2);
    rst = 1'b1;
    next(); #3;
    chk("perf.rst_stall", stall_cycles, 32'd0);
    chk("perf.rst_fwd", fwd_events, 32'd0);
    rst = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fwd_hazard_unit
`default_nettype wire
